// File: rtl/mem_pkg.sv
// mem_pkg: shared sizing constants, helpers and types for the paged inter-stage memory
// and its writer/reader stages.
package mem_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int NPAGE             = 8;
    localparam int NENT_W            = 8;
    localparam int RAM_WIDTH_DEFAULT = 18;
    localparam int RAM_DEPTH_DEFAULT = 1024;
    localparam int PW                = clog2(NPAGE);
    localparam int AW                = clog2(RAM_DEPTH_DEFAULT);

    typedef logic [PW-1:0]     page_t;
    typedef logic [NENT_W-1:0] nent_t;
    typedef logic [AW-1:0]     addr_t;

    typedef enum logic {IDLE, OPEN} wr_state_e;

endpackage

// File: rtl/mem_page_writer_nent_sat_counter.sv
// nent_sat_counter: enable/clear counter that stops at LIMIT; clear and increment in the
// same cycle yields 1 so a fresh page can take its first entry immediately.
module nent_sat_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         at_lim_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign at_lim_o = (cnt_q == W'(LIMIT));
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = (clr_i ? '0 : cnt_q) + W'(inc_i && (clr_i || !at_lim_o));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_page_writer.sv
// mem_page_writer: stream-to-page write front end with per-page entry counts.
// Define MEM_PAGE_WRITER_DROP_CNT_EN to add the saturating drop_cnt output.
module mem_page_writer #(
    parameter int  RAM_WIDTH = mem_pkg::RAM_WIDTH_DEFAULT,
    parameter int  RAM_DEPTH = mem_pkg::RAM_DEPTH_DEFAULT,
    parameter int  NPAGE     = mem_pkg::NPAGE,
    parameter int  NENT_W    = mem_pkg::NENT_W,
    localparam int AW        = mem_pkg::clog2(RAM_DEPTH),
    localparam int PW        = mem_pkg::clog2(NPAGE)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    bx_start,
    input  logic [PW-1:0]           bx_page,
    input  logic                    bx_end,
    input  logic [RAM_WIDTH-1:0]    din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [AW-1:0]           addra,
    output logic [RAM_WIDTH-1:0]    dina,
    output logic                    wea,
    output logic [NPAGE*NENT_W-1:0] nent_o,
    output logic [NPAGE-1:0]        nent_we,
    output logic                    overflow
`ifdef MEM_PAGE_WRITER_DROP_CNT_EN
    ,
    output logic [NENT_W-1:0]       drop_cnt
`endif
);
    import mem_pkg::*;

    localparam int EW      = AW - PW;
    localparam int MAX_ENT = RAM_DEPTH / NPAGE;

    wr_state_e                 state_q, state_d;
    logic [PW-1:0]             page_q, page_d;
    logic [AW-1:0]             addra_q, addra_d;
    logic [RAM_WIDTH-1:0]      dina_q, dina_d;
    logic                      wea_q, wea_d;
    logic [NPAGE-1:0]          we_q, we_d;
    logic [NPAGE*NENT_W-1:0]   nent_q, nent_d;
    logic [NENT_W-1:0]         cnt;
    logic                      cnt_full, acc;

    assign din_ready = (state_q == OPEN) | bx_start;
    assign acc       = din_valid & din_ready;

    // A datum accepted alongside bx_start belongs to the new page, so the counter restarts at 1.
    nent_sat_counter #(.W(NENT_W), .LIMIT(MAX_ENT)) u_cnt (
        .clk(clk), .rstn(rstn), .clr_i(bx_start), .inc_i(acc),
        .cnt_o(cnt), .at_lim_o(cnt_full)
    );

`ifdef MEM_PAGE_WRITER_DROP_CNT_EN
    logic drop_full;
    nent_sat_counter #(.W(NENT_W), .LIMIT((1 << NENT_W) - 1)) u_drop (
        .clk(clk), .rstn(rstn), .clr_i(bx_start), .inc_i(acc & ~bx_start & cnt_full),
        .cnt_o(drop_cnt), .at_lim_o(drop_full)
    );
    assign overflow = |drop_cnt;
`else
    logic ovf_q, ovf_d;
    assign ovf_d    = bx_start ? 1'b0 : (ovf_q | (acc & cnt_full));
    assign overflow = ovf_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end
`endif

    always_comb begin
        state_d = bx_start ? OPEN : (bx_end ? IDLE : state_q);
        page_d  = bx_start ? bx_page : page_q;
        wea_d   = acc & (bx_start | ~cnt_full);
        addra_d = wea_d ? {page_d, (bx_start ? {EW{1'b0}} : cnt[EW-1:0])} : addra_q;
        dina_d  = wea_d ? din : dina_q;
        we_d    = '0;
        nent_d  = nent_q;
        if (state_q == OPEN && (bx_start || bx_end)) begin
            we_d[page_q] = 1'b1;
            nent_d[page_q*NENT_W +: NENT_W] = bx_start ? cnt : cnt + NENT_W'(wea_d);
        end
        // Opening after closing lets the zeroed count win when both name the same page.
        if (bx_start) begin
            we_d[bx_page] = 1'b1;
            nent_d[bx_page*NENT_W +: NENT_W] = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            page_q  <= '0;
            addra_q <= '0;
            dina_q  <= '0;
            wea_q   <= 1'b0;
            we_q    <= '0;
            nent_q  <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            wea_q   <= wea_d;
            we_q    <= we_d;
            nent_q  <= nent_d;
        end
    end

    assign addra   = addra_q;
    assign dina    = dina_q;
    assign wea     = wea_q;
    assign nent_we = we_q;
    assign nent_o  = nent_q;

endmodule

// File: doc/mem_page_writer.md
Name: mem_page_writer

Overview:
- Write-side front end for the paged inter-stage memory used between algorithm steps of the L1 tracking chain.
- Accepts a valid/ready stream of RAM_WIDTH-bit stubs, grouped into bunch crossings (BX).
- Each BX maps to one of NPAGE pages. The block generates the memory write address, data and enable for that page.
- Maintains a per-page entry count and publishes it to the memory's per-page entry-count registers via one-hot write strobes.

Parameters:
- RAM_WIDTH, 18, data word width; matches the downstream memory.
- RAM_DEPTH, 1024, total memory entries; address width AW = clog2(RAM_DEPTH).
- NPAGE, 8, number of pages; power of two; PW = clog2(NPAGE).
- NENT_W, 8, width of each entry-count word.
- MAX_ENT, RAM_DEPTH/NPAGE, entry capacity per page; must be ≤ 2^NENT_W − 1.

Ports:
- clk, in, 1, single clock for all logic.
- rstn, in, 1, asynchronous active-low reset.
- bx_start, in, 1, one-cycle pulse that opens page bx_page.
- bx_page, in, PW, page index sampled with bx_start.
- bx_end, in, 1, one-cycle pulse that closes the open page.
- din, in, RAM_WIDTH, stub data.
- din_valid, in, 1, din is valid.
- din_ready, out, 1, block accepts din this cycle.
- addra, out, AW, memory write address = {page, entry[AW-PW-1:0]}.
- dina, out, RAM_WIDTH, memory write data.
- wea, out, 1, memory write enable.
- nent_o, out, NPAGE*NENT_W, entry-count word for page p in bits [p*NENT_W +: NENT_W].
- nent_we, out, NPAGE, one-hot (or two-hot) per-page count write strobe.
- overflow, out, 1, sticky flag: an entry was dropped in the current page.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; addra, dina, wea, nent_we, nent_o, overflow all 0; din_ready=0; internal count=0.
- States:
  - IDLE: no page open.
  - OPEN: page cur_page accepting data.
- din_ready=1 only in OPEN, or in IDLE in the same cycle as bx_start (combinational from state and bx_start).
- Accept condition: din_valid & din_ready.
- All memory-side outputs are registered; latency is 1 clk from accept to wea.
- bx_start in IDLE:
  - cur_page←bx_page, cnt←0, overflow←0, go to OPEN.
  - Next cycle: nent_we[bx_page]=1 with nent_o field=0, clearing the stale count.
- Accept in OPEN with cnt<MAX_ENT:
  - Next cycle: wea=1, addra={cur_page, cnt}, dina=din; cnt←cnt+1.
- Accept with cnt==MAX_ENT:
  - No write; cnt holds; overflow←1 (sticky until the next page opens).
- bx_end in OPEN:
  - Next cycle: nent_we[cur_page]=1 with field=final cnt, including any accept in the same cycle; go to IDLE.
- bx_start in OPEN (implicit close):
  - Close cur_page as for bx_end and open bx_page in the same cycle.
  - nent_we carries both bits, each field with its own value.
  - If bx_page==cur_page, the open (count 0) wins.
- Data-to-page binding on the bx_start cycle: din accepted that cycle belongs to the NEW page and is written at entry 0, with cnt←1.
- bx_start and bx_end together: bx_start takes priority; bx_end is ignored.
- bx_end in IDLE: ignored.
- din_valid with din_ready=0: held off, no write.
- nent_o fields not strobed this cycle hold their last value.
- nent_we and wea are single-cycle pulses.
- Reset mid-page: all state clears; no nent_we is issued for the aborted page.

Optional Feature:
- Macro: MEM_PAGE_WRITER_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt (NENT_W bits): count of entries dropped in the current page.
  - Saturates at all-ones and clears on page open.
  - overflow = (drop_cnt != 0).
- When undefined:
  - Port absent; only the sticky overflow flag exists.

Decomposition:
- Shared package mem_pkg holds:
  - clog2 function.
  - Constants NPAGE, NENT_W, RAM_WIDTH_DEFAULT.
  - typedefs page_t, nent_t, addr_t.
  - Shared with the memory and reader stages.
- One sub-module: nent_sat_counter (an enable/clear counter with saturation at a limit). Used for cnt, and for drop_cnt when enabled.

Test Plan:
- Reset then bx_start page 3, 5 accepts, bx_end:
  - wea at addra 0x180–0x184.
  - nent_we=0x08 with field 0 one cycle after start.
  - nent_we=0x08 with field 5 one cycle after end.
- Page 2 open, 130 accepts (MAX_ENT=128):
  - 128 writes at 0x100–0x17F; overflow=1; final count 128.
  - With the macro defined: drop_cnt=2.
- Page 1 open with 4 entries; bx_start page 6 with a concurrent accept:
  - nent_we=0x42; page-1 field 4, page-6 field 0.
  - Datum written at 0x300.
  - A bx_end 3 cycles later gives page-6 count 4 if 3 more accepts occur.
- bx_end and bx_start(page 0) in the same cycle while page 5 is open:
  - Page 5 closes and page 0 opens.
  - State stays OPEN; nent_we=0x21.
- din_valid=1 in IDLE without bx_start:
  - din_ready=0; no wea; counts unchanged.
- rstn low mid-page after 3 writes:
  - All outputs go to 0 immediately; no nent_we is issued.
  - After release, the next bx_start opens cleanly with count 0.
